fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_if.sv | 40 ++++
 rtl/fetch_buf.sv | 70 +++++++
 rtl/fetch_unit.sv | 72 +++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch slice: instruction width, buffer entry layout, length decode.
// Pure declarations; no latency, no flow control.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          ILEN             = 32;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] data;
        logic            compressed;
    } entry_t;

    function automatic logic is_compressed(input logic [ILEN-1:0] word);
        return word[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bundle: instruction ROM port, redirect request and decode handshake.
// master = fetch unit, slave = ROM/decode/branch environment; backpressure via inst_ready.
interface fetch_if;
    import fetch_pkg::*;

    logic [ILEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_data;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [ILEN-1:0] inst_pc;
    logic            inst_compressed;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output inst_compressed
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  inst_compressed
    );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of decoded instructions with flush; head presented straight from a register.
// One-cycle push-to-head latency; caller must not push when full unless popping in the same cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  entry_t     push_dat,
    input  logic       pop,
    output entry_t     head_dat,
    output logic [1:0] count
);

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = push_dat;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        slot1_d = push_dat;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy stays put; the new entry lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        slot0_d = push_dat;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_dat = slot0_q;
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential/redirected PC generation over a 1-cycle ROM, 16/32-bit length decode, 2-deep output buffer.
// Two edges from issue to inst_valid; when the buffer is full the ROM address is replayed until decode drains it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    logic [ILEN-1:0] req_pc_q, req_pc_d;
    logic            req_valid_q, req_valid_d;

    logic            rsp_comp;
    logic [ILEN-1:0] rsp_word;
    logic [ILEN-1:0] fetch_addr;
    logic            push;
    logic            pop;
    logic [1:0]      count;
    entry_t          push_dat;
    entry_t          head_dat;

    always_comb begin
        rsp_comp = is_compressed(bus.imem_data);
        rsp_word = rsp_comp ? {16'h0000, bus.imem_data[15:0]} : bus.imem_data;
        pop      = (count != 2'd0) && bus.inst_ready;
        push     = req_valid_q && !bus.redirect_valid && ((count != 2'd2) || pop);
        push_dat = '{pc: req_pc_q, data: rsp_word, compressed: rsp_comp};

        // Without a push the same address is re-read, so the ROM returns the same word next cycle.
        if (bus.redirect_valid) begin
            fetch_addr = {bus.redirect_pc[ILEN-1:1], 1'b0};
        end else if (push) begin
            fetch_addr = req_pc_q + (rsp_comp ? 32'd2 : 32'd4);
        end else begin
            fetch_addr = req_pc_q;
        end

        req_pc_d    = fetch_addr;
        req_valid_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bus.redirect_valid),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign bus.imem_addr       = fetch_addr;
    assign bus.inst_valid      = (count != 2'd0);
    assign bus.inst_pc         = head_dat.pc;
    assign bus.inst_data       = head_dat.data;
    assign bus.inst_compressed = head_dat.compressed;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boot/stall/redirect/reset cases plus randomized ready/redirect traffic.
// Reference is a program-order stream model: each accepted instruction must be the next one from the ROM.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_if wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wbus.master)
    );

    logic [15:0] mem [0:1023];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [9:0] i;
        i = 10'(a >> 1);
        return {mem[i + 10'd1], mem[i]};
    endfunction

    always @(posedge clk) begin
        bus.imem_data  <= rom_word(bus.imem_addr);
        wbus.imem_data <= rom_word(wbus.imem_addr);
    end

    int          vectors;
    int          miscompares;
    int          delivered;
    logic [31:0] exp_pc;
    bit          prev_hold;
    logic [31:0] prev_pc, prev_data, prev_addr;
    logic        prev_comp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then judge what the next rising edge will transfer.
    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [31:0] w;
        logic        c;
        @(negedge clk);
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        chk("addr_align", 32'(bus.imem_addr[0]), 32'd0);
        if (prev_hold) begin
            chk("hold_pc",   bus.inst_pc,   prev_pc);
            chk("hold_data", bus.inst_data, prev_data);
            chk("hold_comp", 32'(bus.inst_compressed), 32'(prev_comp));
        end
        if (bus.inst_valid && rdy) begin
            w = rom_word(exp_pc);
            c = (w[1:0] != 2'b11);
            chk("stream_pc",   bus.inst_pc, exp_pc);
            chk("stream_data", bus.inst_data, c ? {16'h0000, w[15:0]} : w);
            chk("stream_comp", 32'(bus.inst_compressed), 32'(c));
            exp_pc = exp_pc + (c ? 32'd2 : 32'd4);
            delivered++;
        end
        if (rv) exp_pc = {rpc[31:1], 1'b0};
        prev_hold = bus.inst_valid && !rdy && !rv;
        prev_pc   = bus.inst_pc;
        prev_data = bus.inst_data;
        prev_comp = bus.inst_compressed;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        delivered   = 0;
        exp_pc      = 32'h0;
        prev_hold   = 1'b0;
        prev_pc     = '0;
        prev_data   = '0;
        prev_comp   = 1'b0;
        prev_addr   = '0;

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h0093;
        mem[1]     = 16'h0050;
        mem[2]     = 16'h4505;
        mem[3]     = 16'h0113;
        mem[4]     = 16'h00A0;
        mem[1022]  = 16'h0013;
        mem[1023]  = 16'h0000;

        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        wbus.inst_ready     = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = '0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_pc",    bus.inst_pc, 32'd0);
        chk("rst_data",  bus.inst_data, 32'd0);
        chk("rst_comp",  32'(bus.inst_compressed), 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'd0);
        chk("rst_waddr", wbus.imem_addr, 32'hFFFF_FFFC);

        // Boot sequence: 32-bit, 16-bit, 32-bit at 0, 4, 6.
        rst_n = 1'b1;
        cyc(1, 0, 0);
        chk("boot_valid0", 32'(bus.inst_valid), 32'd0);
        chk("boot_addr1",  bus.imem_addr, 32'd4);
        chk("wrap_addr",   wbus.imem_addr, 32'h0000_0000);
        cyc(1, 0, 0);
        chk("boot_valid1", 32'(bus.inst_valid), 32'd1);
        chk("boot_pc0",    bus.inst_pc, 32'd0);
        chk("boot_comp0",  32'(bus.inst_compressed), 32'd0);
        cyc(1, 0, 0);
        chk("boot_pc4",    bus.inst_pc, 32'd4);
        chk("boot_comp4",  32'(bus.inst_compressed), 32'd1);
        chk("boot_data4",  bus.inst_data, 32'h0000_4505);
        cyc(1, 0, 0);
        chk("boot_pc6",    bus.inst_pc, 32'd6);
        chk("boot_comp6",  32'(bus.inst_compressed), 32'd0);
        chk("boot_data6",  bus.inst_data, 32'h00A0_0113);

        // Decode stall: buffer fills, address replays, stream resumes without gaps.
        repeat (3) cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            if (i >= 2) begin
                chk("stall_count", 32'(u_dut.u_buf.count_q), 32'd2);
                chk("stall_replay", bus.imem_addr, prev_addr);
            end
            prev_addr = bus.imem_addr;
        end
        repeat (6) cyc(1, 0, 0);

        // Redirect to an odd target while full.
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 32'h0000_0101);
        chk("redir_addr", bus.imem_addr, 32'h0000_0100);
        cyc(1, 0, 0);
        chk("redir_flush", 32'(bus.inst_valid), 32'd0);
        cyc(1, 0, 0);
        chk("redir_valid", 32'(bus.inst_valid), 32'd1);
        chk("redir_pc",    bus.inst_pc, 32'h0000_0100);
        repeat (4) cyc(1, 0, 0);

        // Back-to-back redirects: only the second target may surface.
        cyc(1, 1, 32'h0000_0040);
        cyc(1, 1, 32'h0000_0080);
        chk("b2b_flush0", 32'(bus.inst_valid), 32'd0);
        cyc(1, 0, 0);
        chk("b2b_flush1", 32'(bus.inst_valid), 32'd0);
        cyc(1, 0, 0);
        chk("b2b_valid",  32'(bus.inst_valid), 32'd1);
        chk("b2b_pc",     bus.inst_pc, 32'h0000_0080);

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom % 1024);
        end

        // Asynchronous reset with a full buffer.
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("pre_rst_count", 32'(u_dut.u_buf.count_q), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.inst_valid), 32'd0);
        chk("arst_count", 32'(u_dut.u_buf.count_q), 32'd0);
        chk("arst_pc",    bus.inst_pc, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        cyc(1, 0, 0);
        chk("rerun_valid0", 32'(bus.inst_valid), 32'd0);
        cyc(1, 0, 0);
        chk("rerun_valid1", 32'(bus.inst_valid), 32'd1);
        chk("rerun_pc0",    bus.inst_pc, 32'd0);
        repeat (8) cyc(1, 0, 0);

        chk("progress", 32'(delivered > 1000), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
